// File: rtl/mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_bridge                                                   |
// | Description : Memory-port bus slave serving an internal byte-maskable RAM  |
// |               or an external peripheral port, with single-pulse ack and   |
// |               release handshake. Optional macro BUS_TIMEOUT_EN adds a     |
// |               peripheral timeout with a sticky err_o flag.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_bridge #(
  parameter int         RAM_ADDR_WIDTH = 12,
  parameter int         RAM_WAIT       = 0,
  parameter logic [3:0] PERIPH_NIBBLE  = 4'hF,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        psel_o,
  output logic [31:0] paddr_o,
  output logic        pwe_o,
  output logic [3:0]  pmask_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  output logic        err_o
);

  localparam int         c_depth     = 1 << RAM_ADDR_WIDTH;
  localparam logic       c_has_wait  = (RAM_WAIT > 0);
  localparam logic [3:0] c_wait_last = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAM_ACC  = 3'd1,
    S_RAM_WAIT = 3'd2,
    S_PERIPH   = 3'd3,
    S_ACK      = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [RAM_ADDR_WIDTH-1:0] r_idx;
  logic                      r_we;
  logic [3:0]                r_mask;
  logic [31:0]               r_wdata;
  logic                      r_periph;
  logic [3:0]                r_wait_cnt;
  logic [31:0]               w_ram_rdata;
  logic                      w_ram_en;
  logic                      w_wait_done;
  logic                      w_timeout;
  logic                      w_is_periph;

  if (RAM_WAIT < 0 || RAM_WAIT > 15 || TIMEOUT_CYCLES < 1 || RAM_ADDR_WIDTH < 1 ||
      RAM_ADDR_WIDTH > 30) begin : g_param_check
    $error("mem_bridge: parameter out of range");
  end

  assign w_is_periph = (addr_i[31:28] == PERIPH_NIBBLE);
  assign w_ram_en    = (r_state == S_RAM_ACC);
  assign w_wait_done = (r_wait_cnt == c_wait_last);

  // One narrow RAM per byte lane so each lane write enable maps onto a BRAM byte enable.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [0:c_depth-1];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (w_ram_en) begin
        if (r_we) begin
          if (r_mask[g]) begin
            r_mem[r_idx] <= r_wdata[8*g +: 8];
          end
        end else begin
          r_q <= r_mem[r_idx];
        end
      end
    end

    assign w_ram_rdata[8*g +: 8] = r_q;
  end

`ifdef BUS_TIMEOUT_EN
  localparam int c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_err;

  assign w_timeout = (r_to_cnt == c_to_last);
  assign err_o     = r_err;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_PERIPH) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      // A pready on the expiry edge wins, so the flag is only raised without it.
      if (r_state == S_PERIPH && !pready_i && w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (sel_i) begin
          w_next = w_is_periph ? S_PERIPH : S_RAM_ACC;
        end
      end
      S_RAM_ACC:  w_next = c_has_wait ? S_RAM_WAIT : S_ACK;
      S_RAM_WAIT: begin
        if (w_wait_done) begin
          w_next = S_ACK;
        end
      end
      S_PERIPH: begin
        if (pready_i || w_timeout) begin
          w_next = S_ACK;
        end
      end
      S_ACK:      w_next = S_RELEASE;
      S_RELEASE: begin
        if (!sel_i) begin
          w_next = S_IDLE;
        end
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_mask     <= 4'd0;
      r_wdata    <= 32'd0;
      r_periph   <= 1'b0;
      r_wait_cnt <= 4'd0;
      data_o     <= 32'd0;
      ack_o      <= 1'b0;
      psel_o     <= 1'b0;
      paddr_o    <= 32'd0;
      pwe_o      <= 1'b0;
      pmask_o    <= 4'd0;
      pwdata_o   <= 32'd0;
    end else begin
      r_state <= w_next;
      ack_o   <= (r_state == S_ACK);
      case (r_state)
        S_IDLE: begin
          if (sel_i) begin
            r_idx    <= addr_i[RAM_ADDR_WIDTH+1:2];
            r_we     <= we_i;
            r_mask   <= wr_mask_i;
            r_wdata  <= data_i;
            r_periph <= w_is_periph;
            if (w_is_periph) begin
              psel_o   <= 1'b1;
              paddr_o  <= addr_i;
              pwe_o    <= we_i;
              pmask_o  <= wr_mask_i;
              pwdata_o <= data_i;
            end
          end
        end
        S_RAM_ACC:  r_wait_cnt <= 4'd0;
        S_RAM_WAIT: r_wait_cnt <= r_wait_cnt + 4'd1;
        S_PERIPH: begin
          if (pready_i) begin
            psel_o <= 1'b0;
            if (!r_we) begin
              data_o <= prdata_i;
            end
          end else if (w_timeout) begin
            psel_o <= 1'b0;
            data_o <= 32'hDEAD_BEEF;
          end
        end
        S_ACK: begin
          // RAM read word has been sitting in the lane registers since RAM_ACC.
          if (!r_periph && !r_we) begin
            data_o <= w_ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
